// File: rtl/btn_defs.sv
// Shared definitions for the switch debounce slice: default sizing, the simulation
// debounce length and the per-channel FSM encoding. Related option: DEBOUNCE_FALL_PULSE_EN.
package btn_defs;

  localparam int NUM_SW              = 4;
  localparam int DEBOUNCE_CYCLES     = 500000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } db_state_e;

  // Counter must hold 0 .. DEBOUNCE_CYCLES-1.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch bit: 2-flop synchroniser, hold counter, two-state FSM and registered edge pulses.
// DEBOUNCE_FALL_PULSE_EN adds fall_pulse_o; without it only the rising pulse exists.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = btn_defs::DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_raw_i,
  output logic                sw_stable_o,
  output logic                rise_pulse_o,
`ifdef DEBOUNCE_FALL_PULSE_EN
  output logic                fall_pulse_o,
`endif
  output btn_defs::db_state_e state_o
);

  localparam int               CNT_W    = btn_defs::cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q;
  logic                sync2_q;
  logic                stable_q;
  logic                rise_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  btn_defs::db_state_e state_q;
  logic                differs;
  logic                accept;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic                fall_q;
`endif

  // accept fires on the DEBOUNCE_CYCLES-th consecutive differing sample; with a
  // length of 1 that is the very first one, so STABLE can accept directly.
  assign differs = (sync2_q != stable_q);
  assign accept  = differs && (cnt_q == CNT_LAST);
  assign cnt_d   = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
      state_q  <= btn_defs::ST_STABLE;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= sw_raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall_q  <= 1'b0;
`endif
      case (state_q)
        btn_defs::ST_STABLE: begin
          if (accept) begin
            stable_q <= sync2_q;
            rise_q   <= sync2_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q   <= ~sync2_q;
`endif
            cnt_q    <= '0;
          end else if (differs) begin
            state_q <= btn_defs::ST_COUNT;
            cnt_q   <= cnt_d;
          end
        end
        btn_defs::ST_COUNT: begin
          if (!differs) begin
            state_q <= btn_defs::ST_STABLE;
            cnt_q   <= '0;
          end else if (accept) begin
            stable_q <= sync2_q;
            rise_q   <= sync2_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q   <= ~sync2_q;
`endif
            state_q  <= btn_defs::ST_STABLE;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
      endcase
    end
  end

  assign sw_stable_o  = stable_q;
  assign rise_pulse_o = rise_q;
  assign state_o      = state_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
  assign fall_pulse_o = fall_q;
`endif

endmodule

// File: rtl/switch_debounce.sv
// Debounces NUM_SW raw switches into clean levels plus one-cycle edge pulses.
// Define DEBOUNCE_FALL_PULSE_EN to add the fall_pulse output.
module switch_debounce #(
  parameter int NUM_SW          = btn_defs::NUM_SW,
  parameter int DEBOUNCE_CYCLES = btn_defs::DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_stable,
`ifdef DEBOUNCE_FALL_PULSE_EN
  output logic [NUM_SW-1:0] fall_pulse,
`endif
  output logic [NUM_SW-1:0] rise_pulse
);

  btn_defs::db_state_e chan_state [NUM_SW];

  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .sw_raw_i    (sw_raw[i]),
      .sw_stable_o (sw_stable[i]),
      .rise_pulse_o(rise_pulse[i]),
`ifdef DEBOUNCE_FALL_PULSE_EN
      .fall_pulse_o(fall_pulse[i]),
`endif
      .state_o     (chan_state[i])
    );

    // The clean level may only move out of a counting run (or out of reset).
    stable_moves_from_count: assert property (@(posedge clk) disable iff (reset)
      (sw_stable[i] != $past(sw_stable[i])) |->
        ($past(reset) || (DEBOUNCE_CYCLES == 1) ||
         ($past(chan_state[i]) == btn_defs::ST_COUNT)));
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: a window-based reference model predicts each edge,
// a negedge monitor compares. Build with or without DEBOUNCE_FALL_PULSE_EN.
module tb_switch_debounce;

  localparam int NUM_SW = 4;
  localparam int D      = btn_defs::DEBOUNCE_CYCLES_SIM;
  localparam int W      = 3 * NUM_SW;

  logic              clk;
  logic              reset;
  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] sw_stable;
  logic [NUM_SW-1:0] rise_pulse;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic [NUM_SW-1:0] fall_pulse;
`endif

  int checks   = 0;
  int failures = 0;
  int pushed   = 0;
  int popped   = 0;

  logic [W-1:0]      exp_q[$];
  logic [NUM_SW-1:0] raw_hist[$];
  bit                rst_hist[$];
  logic [NUM_SW-1:0] stable_m;
  logic [NUM_SW-1:0] rnd_raw;
  logic [W-1:0]      mon_exp;

  switch_debounce #(
    .NUM_SW         (NUM_SW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
`ifdef DEBOUNCE_FALL_PULSE_EN
    .fall_pulse(fall_pulse),
`endif
    .rise_pulse(rise_pulse)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [NUM_SW-1:0] act,
                       input logic [NUM_SW-1:0] exp_v, input int edge_n);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s edge %0d: got %b expected %b", name, edge_n, act, exp_v);
    end
  endtask

  // Synchronised value the debouncer reads at edge t: raw sampled two edges earlier,
  // or 0 if a reset edge cleared the synchroniser in between.
  function automatic logic [NUM_SW-1:0] sync_seen(input int t);
    if (t < 2) return '0;
    if (rst_hist[t-1] || rst_hist[t-2]) return '0;
    return raw_hist[t-2];
  endfunction

  // A channel flips at edge t iff the last D reads (edges t-D+1..t) all differ from
  // its current clean level and none of those edges was a reset.
  task automatic model_edge(output logic [W-1:0] word);
    int                t;
    bit                acc;
    logic [NUM_SW-1:0] seen;
    logic [NUM_SW-1:0] rise_m;
    logic [NUM_SW-1:0] fall_m;
    t      = raw_hist.size() - 1;
    rise_m = '0;
    fall_m = '0;
    if (rst_hist[t]) begin
      stable_m = '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        acc = (t - D + 1 >= 0);
        for (int k = 0; k < D; k++) begin
          if (acc) begin
            seen = sync_seen(t - k);
            if (rst_hist[t-k] || (seen[i] == stable_m[i])) acc = 0;
          end
        end
        if (acc) begin
          rise_m[i]   = ~stable_m[i];
          fall_m[i]   = stable_m[i];
          stable_m[i] = ~stable_m[i];
        end
      end
    end
    word = {fall_m, rise_m, stable_m};
  endtask

  // driver
  task automatic step(input logic [NUM_SW-1:0] raw, input bit rst);
    logic [W-1:0] word;
    sw_raw = raw;
    reset  = rst;
    @(posedge clk);
    raw_hist.push_back(raw);
    rst_hist.push_back(rst);
    model_edge(word);
    exp_q.push_back(word);
    pushed++;
    #1;
  endtask

  task automatic hold(input logic [NUM_SW-1:0] raw, input int n);
    for (int j = 0; j < n; j++) step(raw, 1'b0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      check("sw_stable", sw_stable, mon_exp[NUM_SW-1:0], popped);
      check("rise_pulse", rise_pulse, mon_exp[2*NUM_SW-1:NUM_SW], popped);
`ifdef DEBOUNCE_FALL_PULSE_EN
      check("fall_pulse", fall_pulse, mon_exp[3*NUM_SW-1:2*NUM_SW], popped);
`endif
      popped++;
    end
  end

  initial begin
    sw_raw   = '0;
    reset    = 1'b1;
    stable_m = '0;
    rnd_raw  = '0;
    #1;

    // reset with all switches high, then first edge after release
    repeat (3) step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);

    // single channel rising and held
    repeat (2) step(4'b0000, 1'b1);
    hold(4'b0001, 9);

    // bouncing channel 1 never accepted
    hold(4'b0011, 3);
    hold(4'b0001, 2);
    hold(4'b0011, 3);
    hold(4'b0001, 8);

    // channel 0 low for D-1 reads (rejected), then exactly D reads (accepted)
    hold(4'b0000, D - 1);
    hold(4'b0001, 6);
    hold(4'b0000, D);
    hold(4'b0001, 8);

    // all channels rising together
    step(4'b0000, 1'b1);
    hold(4'b0000, 3);
    hold(4'b1111, 8);

    // reset in the middle of a count with the switch still high
    step(4'b0000, 1'b1);
    hold(4'b0000, 2);
    hold(4'b0100, 4);
    repeat (2) step(4'b0100, 1'b1);
    hold(4'b0100, 9);

    // channel 3 up then down (falling edge)
    hold(4'b1100, 8);
    hold(4'b0100, 8);

    // raw changes while reset is held are ignored
    repeat (3) step(4'($urandom_range(0, 15)), 1'b1);
    hold(4'b0000, 3);

    // randomized bouncing with occasional resets
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_SW; i++) begin
        if ($urandom_range(0, 5) == 0) rnd_raw[i] = ~rnd_raw[i];
      end
      step(rnd_raw, ($urandom_range(0, 99) == 0));
    end
    hold(4'b0000, 8);

    // bounded drain of the scoreboard
    for (int n = 0; n < 4 && exp_q.size() != 0; n++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || popped != pushed) begin
      failures++;
      $display("FAIL drain: got popped=%0d left=%0d expected popped=%0d left=0",
               popped, exp_q.size(), pushed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
